// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: mode/setting controller for a min:sec clock.
//
// Sequences RUN -> SET_MIN -> SET_SEC -> RUN on MODE pulses. While setting,
// time is frozen, UP steps the selected field, the selected digit pair
// blinks at the EN1HZ rate, and the controller drops back to RUN after
// TIMEOUT idle EN1HZ ticks.
//
// Ports:
//   CLK        in   50 MHz system clock, rising edge
//   RST        in   asynchronous reset, active low
//   EN1HZ      in   one-CLK-wide 1 Hz enable
//   MODE       in   debounced one-cycle pulse, steps the setting mode
//   UP         in   debounced one-cycle pulse, increments the selected field
//   CLR        in   debounced one-cycle pulse, clears the time
//   SEC_EN     out  seconds counter enable (EN1HZ gated to RUN), combinational
//   SEC_INC    out  one-cycle seconds increment strobe, registered
//   MIN_INC    out  one-cycle minutes increment strobe, registered
//   CNT_CLR    out  one-cycle clear strobe for both counters, registered
//   BLANK_SEC  out  blank the seconds digit pair
//   BLANK_MIN  out  blank the minutes digit pair
//   SETTING    out  high in either setting state (decimal-point indicator)
//
// State table:
//   state   | meaning
//   RUN     | normal timekeeping, SEC_EN follows EN1HZ, UP ignored
//   SET_MIN | time frozen, UP increments minutes, minutes blink
//   SET_SEC | time frozen, UP increments seconds, seconds blink
//
// TIMEOUT must be in 2..15 (the idle counter is 4 bits wide).

module clock_set_ctrl #(
    parameter int TIMEOUT = 10
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN1HZ,
    input  logic MODE,
    input  logic UP,
    input  logic CLR,
    output logic SEC_EN,
    output logic SEC_INC,
    output logic MIN_INC,
    output logic CNT_CLR,
    output logic BLANK_SEC,
    output logic BLANK_MIN,
    output logic SETTING
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_MIN = 2'd1,
        SET_SEC = 2'd2
    } state_t;

    // The edge that would carry the idle count to TIMEOUT is the edge that
    // leaves the setting state, so the stored count tops out at TIMEOUT-1.
    localparam logic [3:0] IDLE_LAST = 4'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] idle_cnt;
    logic       phase;
    logic       sec_inc_q;
    logic       min_inc_q;
    logic       cnt_clr_q;

    logic       in_setting;
    logic       activity;
    logic       timeout_hit;
    logic       state_change;

    assign in_setting   = (state != RUN);
    assign activity     = MODE | UP | CLR;
    // Any button press in the same cycle counts as activity and defers the timeout.
    assign timeout_hit  = in_setting && EN1HZ && !activity && (idle_cnt == IDLE_LAST);
    assign state_change = (state_nxt != state);

    always_comb begin
        state_nxt = state;
        if (MODE) begin
            case (state)
                RUN:     state_nxt = SET_MIN;
                SET_MIN: state_nxt = SET_SEC;
                SET_SEC: state_nxt = RUN;
                default: state_nxt = RUN;
            endcase
        end else if (timeout_hit) begin
            state_nxt = RUN;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            idle_cnt <= 4'd0;
        end else if (state_change || activity) begin
            idle_cnt <= 4'd0;
        end else if (in_setting && EN1HZ) begin
            idle_cnt <= idle_cnt + 4'd1;
        end
    end

    // Phase restarts at 0 on every state entry so the digits are visible
    // right after a mode change; RUN never toggles it.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            phase <= 1'b0;
        end else if (state_change) begin
            phase <= 1'b0;
        end else if (in_setting && EN1HZ) begin
            phase <= ~phase;
        end
    end

    // Strobes are sampled from single-cycle pulses, so each pulse yields
    // exactly one strobe cycle. MODE or CLR in the same cycle drops the UP.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sec_inc_q <= 1'b0;
            min_inc_q <= 1'b0;
            cnt_clr_q <= 1'b0;
        end else begin
            sec_inc_q <= UP && !MODE && !CLR && (state == SET_SEC);
            min_inc_q <= UP && !MODE && !CLR && (state == SET_MIN);
            cnt_clr_q <= CLR;
        end
    end

    assign SEC_EN    = EN1HZ && (state == RUN);
    assign SEC_INC   = sec_inc_q;
    assign MIN_INC   = min_inc_q;
    assign CNT_CLR   = cnt_clr_q;
    assign BLANK_MIN = (state == SET_MIN) && phase;
    assign BLANK_SEC = (state == SET_SEC) && phase;
    assign SETTING   = in_setting;

endmodule
